jtframe_lfbuf_memctl: RTL

- Sequencer that moves pixel lines between the on-chip line buffers of the line-based frame buffer and a 16-bit external memory (SDRAM) port.
- Each line period it first fetches the next display line from the displayed frame into the screen line buffer during H-blank.
- It then dumps the just-completed object line into the drawing frame, clearing each location after it is written.
- It drives the buffer-swap bit `line` and the `fb_done` handshake that advances the line counter.

---
 rtl/jtframe_lfbuf_memctl_pkg.sv | 30 +++
 rtl/jtframe_lfbuf_memctl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_lfbuf_memctl_pkg.sv
// Shared types and address layout for the line-frame-buffer memory sequencer.
// Holds the sequencer state encoding and helpers that place the frame bit,
// line number and pixel index inside the external memory address.
package jtframe_lfbuf_memctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR_ADDR = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_CLR  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Memory address is {frame, line, pixel}, pixel in the LSBs
  localparam int unsigned PIX_LSB = 0;

  function automatic int unsigned line_lsb(input int unsigned hw);
    return hw;
  endfunction

  function automatic int unsigned frame_bit(input int unsigned vw, input int unsigned hw);
    return vw + hw;
  endfunction

  function automatic int unsigned addr_width(input int unsigned vw, input int unsigned hw);
    return 1 + vw + hw;
  endfunction

endpackage

// File: rtl/jtframe_lfbuf_memctl.sv
// Line-frame-buffer memory sequencer.
// Each line: during H-blank reads the next display line (vrender) from the
// displayed frame (~frame) into the screen buffer, then dumps the completed
// object line (ln_v) into the drawing frame, clearing each buffer word.
// Ports:
//   clk, rst               clock, async active-high reset
//   lhbl, lvbl             blanking inputs (active low)
//   vrender, frame         read line / drawing frame select
//   ln_hs, ln_v            core line start pulse and its line number
//   line                   line-buffer half owned by the core
//   fb_addr/fb_din/fb_clr  dump-side buffer port (1-cycle read latency)
//   fb_done                one-cycle pulse when a dump completes
//   rd_addr/fb_dout/scr_we screen-buffer write port
//   mem_*                  16-bit external memory request/ack port
//   rd_ovf                 sticky read-overflow flag, cleared on lvbl fall
module jtframe_lfbuf_memctl
  import jtframe_lfbuf_memctl_pkg::*;
#(
  parameter int unsigned VW   = 8,
  parameter int unsigned HW   = 9,
  parameter int unsigned HLEN = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lhbl,
  input  logic                  lvbl,
  input  logic [VW-1:0]         vrender,
  input  logic                  frame,
  input  logic                  ln_hs,
  input  logic [VW-1:0]         ln_v,
  output logic                  line,
  output logic [HW-1:0]         fb_addr,
  input  logic [15:0]           fb_din,
  output logic                  fb_clr,
  output logic                  fb_done,
  output logic [HW-1:0]         rd_addr,
  output logic [15:0]           fb_dout,
  output logic                  scr_we,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [VW+HW:0]        mem_addr,
  output logic [15:0]           mem_din,
  input  logic [15:0]           mem_dout,
  input  logic                  mem_ack,
  output logic                  rd_ovf
);

  localparam int unsigned AW        = addr_width(VW, HW);
  localparam int unsigned FRAME_POS = frame_bit(VW, HW);
  localparam int unsigned LINE_POS  = line_lsb(HW);
  localparam logic [HW-1:0] LAST    = HW'(HLEN - 1);

  function automatic logic [AW-1:0] mk_addr(input logic f, input logic [VW-1:0] ln,
                                            input logic [HW-1:0] px);
    return (AW'(f) << FRAME_POS) | (AW'(ln) << LINE_POS) | (AW'(px) << PIX_LSB);
  endfunction

  state_e          state_q, state_d;
  logic [HW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   rd_line_q, rd_line_d;
  logic [VW-1:0]   wr_line_q, wr_line_d;
  logic            wr_job_q, wr_job_d;
  logic            armed_q, armed_d;
  logic            hb_pend_q, hb_pend_d;
  logic            lhbl_l_q, lhbl_l_d;
  logic            lvbl_l_q, lvbl_l_d;
  logic            line_q, line_d;
  logic [HW-1:0]   fb_addr_q, fb_addr_d;
  logic            fb_clr_q, fb_clr_d;
  logic            fb_done_q, fb_done_d;
  logic [HW-1:0]   rd_addr_q, rd_addr_d;
  logic [15:0]     fb_dout_q, fb_dout_d;
  logic            scr_we_q, scr_we_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]     mem_din_q, mem_din_d;
  logic            rd_ovf_q, rd_ovf_d;

  logic            hb_fall_c, vb_fall_c, rd_end_c, wr_job_c;

  assign line     = line_q;
  assign fb_addr  = fb_addr_q;
  assign fb_clr   = fb_clr_q;
  assign fb_done  = fb_done_q;
  assign rd_addr  = rd_addr_q;
  assign fb_dout  = fb_dout_q;
  assign scr_we   = scr_we_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign rd_ovf   = rd_ovf_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_line_d  = rd_line_q;
    wr_line_d  = wr_line_q;
    wr_job_d   = wr_job_q;
    line_d     = line_q;
    fb_addr_d  = fb_addr_q;
    rd_addr_d  = rd_addr_q;
    fb_dout_d  = fb_dout_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rd_ovf_d   = rd_ovf_q;
    fb_clr_d   = 1'b0;
    fb_done_d  = 1'b0;
    scr_we_d   = 1'b0;
    lhbl_l_d   = lhbl;
    lvbl_l_d   = lvbl;
    rd_end_c   = 1'b0;
    wr_job_c   = wr_job_q;

    hb_fall_c  = lhbl_l_q & ~lhbl;
    vb_fall_c  = lvbl_l_q & ~lvbl;
    hb_pend_d  = hb_pend_q | hb_fall_c;
    armed_d    = armed_q | ln_hs;
    if (vb_fall_c) rd_ovf_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hb_pend_q) begin
          // keep an edge arriving in the same cycle the pending one is served
          hb_pend_d = hb_fall_c;
          cnt_d     = '0;
          if (armed_q) begin
            line_d    = ~line_q;
            wr_line_d = ln_v;
            wr_job_c  = 1'b1;
            armed_d   = ln_hs;
          end
          wr_job_d = wr_job_c;
          if (lvbl) begin
            rd_line_d  = vrender;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = mk_addr(~frame, vrender, '0);
            state_d    = ST_RD;
          end else if (wr_job_c) begin
            fb_addr_d = '0;
            state_d   = ST_WR_ADDR;
          end
        end
      end

      ST_RD: begin
        if (mem_req_q) begin
          // an issued request always waits for its ack, even past H-blank
          if (mem_ack) begin
            scr_we_d  = 1'b1;
            rd_addr_d = cnt_q;
            fb_dout_d = mem_dout;
            mem_req_d = 1'b0;
            if (cnt_q == LAST) begin
              rd_end_c = 1'b1;
            end else if (lhbl) begin
              rd_end_c = 1'b1;
              rd_ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + HW'(1);
            end
          end
        end else if (lhbl) begin
          rd_end_c = 1'b1;
          rd_ovf_d = 1'b1;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = mk_addr(~frame, rd_line_q, cnt_q);
        end
        if (rd_end_c) begin
          cnt_d = '0;
          if (wr_job_q) begin
            fb_addr_d = '0;
            state_d   = ST_WR_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      // fb_addr already points at cnt; fb_din is valid next cycle
      ST_WR_ADDR: state_d = ST_WR_REQ;

      ST_WR_REQ: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = mk_addr(frame, wr_line_q, cnt_q);
          mem_din_d  = fb_din;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          fb_clr_d  = 1'b1;
          state_d   = ST_WR_CLR;
        end
      end

      ST_WR_CLR: begin
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          fb_done_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d     = cnt_q + HW'(1);
          fb_addr_d = cnt_q + HW'(1);
          state_d   = ST_WR_ADDR;
        end
      end

      ST_DONE: begin
        wr_job_d = 1'b0;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_line_q  <= '0;
      wr_line_q  <= '0;
      wr_job_q   <= 1'b0;
      armed_q    <= 1'b0;
      hb_pend_q  <= 1'b0;
      lhbl_l_q   <= 1'b0;
      lvbl_l_q   <= 1'b0;
      line_q     <= 1'b0;
      fb_addr_q  <= '0;
      fb_clr_q   <= 1'b0;
      fb_done_q  <= 1'b0;
      rd_addr_q  <= '0;
      fb_dout_q  <= '0;
      scr_we_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_line_q  <= rd_line_d;
      wr_line_q  <= wr_line_d;
      wr_job_q   <= wr_job_d;
      armed_q    <= armed_d;
      hb_pend_q  <= hb_pend_d;
      lhbl_l_q   <= lhbl_l_d;
      lvbl_l_q   <= lvbl_l_d;
      line_q     <= line_d;
      fb_addr_q  <= fb_addr_d;
      fb_clr_q   <= fb_clr_d;
      fb_done_q  <= fb_done_d;
      rd_addr_q  <= rd_addr_d;
      fb_dout_q  <= fb_dout_d;
      scr_we_q   <= scr_we_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rd_ovf_q   <= rd_ovf_d;
    end
  end

endmodule
